board_led_tx: RTL and testbench
===============================

BOARD_LED_TX -- requirements
Module: board_led_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4; it sets the sclk half-period and the latch pulse width in clk cycles. Legal range is 1..255.
REQ-002 Port clk, input, 1 bit: the single system clock; all state is rising-edge triggered.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request to transmit one frame.
REQ-005 Port A, input, 9 bits: player-A cell occupancy mask.
REQ-006 Port B, input, 9 bits: player-B cell occupancy mask.
REQ-007 Port win, input, 1 bit: game-won status.
REQ-008 Port tie, input, 1 bit: game-tied status.
REQ-009 Port busy, output, 1 bit: a frame is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-011 Port sclk, output, 1 bit: serial shift clock to the external LED shift-register chain.
REQ-012 Port sdata, output, 1 bit: serial data to the chain.
REQ-013 Port latch, output, 1 bit: storage-register latch pulse to the chain.

Function
REQ-014 The block SHALL snapshot {win, tie, B[8:0], A[8:0]} into a 20-bit frame register on the clk edge where start=1 and busy=0.
REQ-015 start while busy=1 SHALL be ignored; that frame's snapshot SHALL NOT change.
REQ-016 The frame SHALL shift out MSB first:
 - bit19 = win
 - bit18 = tie
 - bits17..9 = B[8..0]
 - bits8..0 = A[8..0]
REQ-017 A cell with both A[i]=1 and B[i]=1 SHALL be transmitted unmodified, with both bits set.
REQ-018 The FSM states SHALL be IDLE, SETUP, HIGH and LATCH.
REQ-019 FSM transitions:
 - IDLE to SETUP on an accepted start.
 - SETUP to HIGH after CLK_DIV cycles.
 - HIGH to SETUP for the next bit after CLK_DIV cycles, or to LATCH after bit0.
 - LATCH to IDLE after CLK_DIV cycles.
REQ-020 In SETUP, sclk SHALL be 0 and sdata SHALL hold the current bit; in HIGH, sclk SHALL be 1 with sdata unchanged.
REQ-021 In LATCH, latch SHALL be 1, sclk 0 and sdata 0; latch SHALL be 0 in all other states.
REQ-022 busy SHALL be 1 from the cycle after start is accepted through the final LATCH cycle, i.e. exactly 41*CLK_DIV cycles.
REQ-023 done SHALL pulse high for exactly one cycle, in the cycle after the final LATCH cycle, with busy=0 in that cycle.
REQ-024 A start coincident with done SHALL be accepted, beginning a new frame back-to-back.
REQ-025 A 20-bit frame-length bit counter and a CLK_DIV-wide divider counter SHALL control sequencing; both SHALL reload at the start of each frame and carry no state between frames.

Reset
REQ-026 While rst=0, outputs SHALL be busy=0, done=0, sclk=0, sdata=0, latch=0, with the FSM in IDLE and all counters and the frame register cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no done pulse.
REQ-028 The first start SHALL be accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-029 The macro BOARD_LED_TX_WIN_BLINK_EN SHALL select win-LED blinking.
REQ-030 With BOARD_LED_TX_WIN_BLINK_EN defined:
 - A 1-bit blink phase SHALL toggle on every done pulse while win=1 at that done.
 - Transmitted bit19 SHALL be win AND NOT phase.
 - Reset SHALL clear the phase to 0.
REQ-031 With BOARD_LED_TX_WIN_BLINK_EN undefined, bit19 SHALL equal the sampled win, and the phase register SHALL be absent.

Verification
REQ-032 Scenario 1: CLK_DIV=4, A=9'h1C0, B=9'h007, win=0, tie=0, one start -> sdata bit sequence 0,0,000000111,111000000; busy high for 164 cycles; one done pulse; exactly 20 sclk rising edges.
REQ-033 Scenario 2: start held high continuously for 400 cycles -> consecutive frames, each with busy high for 164 cycles followed by a 1-cycle busy-low/done gap between frames.
REQ-034 Scenario 3: A is changed to 9'h1FF mid-frame, and start is pulsed mid-frame -> the transmitted frame matches the original snapshot and no extra frame starts.
REQ-035 Scenario 4: rst pulled low at bit 10 -> all outputs are 0 immediately, no done pulse, and a following start transmits a full 20-bit frame.
REQ-036 Scenario 5: CLK_DIV=1, A=B=9'h1FF, win=0, tie=1 -> bit19=0, bits18..0 all 1, busy high for 41 cycles.
REQ-037 Scenario 6 (BOARD_LED_TX_WIN_BLINK_EN defined): win=1, three back-to-back frames -> bit19 is 1,0,1 across the three frames.

Source files
------------

// File: rtl/board_led_tx.sv
// board_led_tx
//   Serialises one tic-tac-toe board frame into an external LED shift-register
//   chain (74HC595-style). A 20-bit snapshot {win, tie, B[8:0], A[8:0]} is taken
//   when a start request is accepted. The snapshot is shifted out MSB first, one
//   bit per sclk period, and is then followed by a storage-register latch pulse.
//
//   Each bit occupies CLK_DIV cycles with sclk low (data setup) followed by
//   CLK_DIV cycles with sclk high. The latch pulse lasts CLK_DIV cycles, so a
//   frame keeps busy high for 41*CLK_DIV cycles.
//
// Parameters
//   CLK_DIV : sclk half-period and latch width in clk cycles (1..255)
//
// Ports
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active low
//   start in  request one frame (ignored while busy)
//   A     in  player-A cell mask
//   B     in  player-B cell mask
//   win   in  game-won status
//   tie   in  game-tied status
//   busy  out frame in progress
//   done  out one-cycle pulse after the latch pulse
//   sclk  out shift clock to the chain
//   sdata out serial data to the chain
//   latch out storage-register latch to the chain
//
// Build options
//   BOARD_LED_TX_WIN_BLINK_EN : when defined, the win LED blinks. A phase bit
//   toggles on every done pulse that sees win=1, and the transmitted win bit is
//   win & ~phase.
module board_led_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] A,
  input  logic [8:0] B,
  input  logic       win,
  input  logic       tie,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       sdata,
  output logic       latch
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'd19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [4:0]       bit_q,   bit_d;
  logic [19:0]      frame_q, frame_d;
  logic             done_q,  done_d;
  logic             div_end;
  logic             win_bit;

  // Every state lasts exactly CLK_DIV cycles. The divider counts down from
  // CLK_DIV-1 and reloads on each state change.
  assign div_end = (div_q == '0);

`ifdef BOARD_LED_TX_WIN_BLINK_EN
  logic phase_q, phase_d;

  // The phase flips in the done cycle. A frame accepted back-to-back in that
  // same cycle must already see the new phase, so the snapshot uses phase_d.
  assign phase_d = phase_q ^ (done_q & win);
  assign win_bit = win & ~phase_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  assign win_bit = win;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // IDLE also covers the done cycle, so a start in that cycle begins
        // the next frame back-to-back.
        if (start) begin
          state_d = SETUP;
          div_d   = DIV_LAST;
          bit_d   = BIT_LAST;
          frame_d = {win_bit, tie, B, A};
        end
      end

      SETUP: begin
        if (div_end) begin
          state_d = HIGH;
          div_d   = DIV_LAST;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      HIGH: begin
        if (div_end) begin
          div_d = DIV_LAST;
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            // Shift only after the sclk-high phase, so sdata stays stable
            // across the rising sclk edge.
            state_d = SETUP;
            bit_d   = bit_q - 1'b1;
            frame_d = {frame_q[18:0], 1'b0};
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      LATCH: begin
        if (div_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          frame_d = '0;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
        frame_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // The outputs decode directly from registered state. Reset forces IDLE
  // asynchronously, which drives every output low at once.
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign sclk  = (state_q == HIGH);
  assign latch = (state_q == LATCH);
  assign sdata = ((state_q == SETUP) || (state_q == HIGH)) & frame_q[19];

endmodule

// File: tb/tb_board_led_tx.sv
module tb_board_led_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_v;
  logic [8:0] A;
  logic [8:0] B;
  logic       win;
  logic       tie;
  logic [1:0] busy_v, done_v, sclk_v, sdata_v, latch_v;

  always #5 clk = ~clk;

  // index 0: CLK_DIV=4, index 1: CLK_DIV=1
  board_led_tx #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(A), .B(B), .win(win), .tie(tie),
    .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]), .sdata(sdata_v[0]),
    .latch(latch_v[0])
  );

  board_led_tx #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(A), .B(B), .win(win), .tie(tie),
    .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]), .sdata(sdata_v[1]),
    .latch(latch_v[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  logic        clr;
  int          rise[2], busy_cnt[2], done_cnt[2], latch_cnt[2], hi_cnt[2];
  int          latch_bad[2], done_busy[2];
  logic [63:0] cap[2];
  logic [1:0]  sclk_prev;
  logic        bprev0, seen0;
  int          run0, idle0;
  int          runs0[$];
  int          gaps0[$];

  always @(negedge clk) begin
    sclk_prev <= sclk_v;
    bprev0    <= busy_v[0];
    if (clr) begin
      for (int i = 0; i < 2; i++) begin
        rise[i]      <= 0;
        busy_cnt[i]  <= 0;
        done_cnt[i]  <= 0;
        latch_cnt[i] <= 0;
        hi_cnt[i]    <= 0;
        latch_bad[i] <= 0;
        done_busy[i] <= 0;
        cap[i]       <= '0;
      end
      run0  <= 0;
      idle0 <= 0;
      seen0 <= 1'b0;
      runs0.delete();
      gaps0.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sclk_v[i] && !sclk_prev[i]) begin
          rise[i] <= rise[i] + 1;
          cap[i]  <= {cap[i][62:0], sdata_v[i]};
        end
        if (busy_v[i]) busy_cnt[i] <= busy_cnt[i] + 1;
        if (sclk_v[i]) hi_cnt[i] <= hi_cnt[i] + 1;
        if (done_v[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          if (busy_v[i]) done_busy[i] <= done_busy[i] + 1;
        end
        if (latch_v[i]) begin
          latch_cnt[i] <= latch_cnt[i] + 1;
          if (sclk_v[i] || sdata_v[i]) latch_bad[i] <= latch_bad[i] + 1;
        end
      end
      if (busy_v[0]) begin
        run0  <= run0 + 1;
        idle0 <= 0;
        if (!bprev0 && seen0) gaps0.push_back(idle0);
      end else begin
        if (bprev0) begin
          runs0.push_back(run0);
          run0  <= 0;
          seen0 <= 1'b1;
          idle0 <= 1;
        end else begin
          idle0 <= idle0 + 1;
        end
      end
    end
  end

  task automatic clr_mon();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    start_v = 2'b00;
    A       = '0;
    B       = '0;
    win     = 1'b0;
    tie     = 1'b0;
    clr     = 1'b1;

    // Reset state, with start requested while in reset
    repeat (3) @(negedge clk);
    start_v = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {62'd0, busy_v},  64'd0);
    chk("rst_done",  {62'd0, done_v},  64'd0);
    chk("rst_sclk",  {62'd0, sclk_v},  64'd0);
    chk("rst_sdata", {62'd0, sdata_v}, 64'd0);
    chk("rst_latch", {62'd0, latch_v}, 64'd0);

    // Scenario 1: the first start is taken on the first edge after reset release
    A       = 9'h1C0;
    B       = 9'h007;
    start_v = 2'b01;
    rst     = 1'b1;
    clr     = 1'b0;
    @(negedge clk);
    start_v = 2'b00;
    chk("s1_busy_first_edge", busy_v[0], 1'b1);
    repeat (170) @(negedge clk);
    chk("s1_frame",     cap[0][19:0], 20'h00FC0);
    chk("s1_sclk_rise", rise[0],      20);
    chk("s1_busy_cyc",  busy_cnt[0],  164);
    chk("s1_done_cnt",  done_cnt[0],  1);
    chk("s1_done_busy", done_busy[0], 0);
    chk("s1_latch_cyc", latch_cnt[0], 4);
    chk("s1_latch_pins",latch_bad[0], 0);
    chk("s1_sclk_hi",   hi_cnt[0],    80);

    // Scenario 2: start held high, back-to-back frames
    clr_mon();
    start_v = 2'b01;
    repeat (400) @(negedge clk);
    start_v = 2'b00;
    repeat (200) @(negedge clk);
    chk("s2_done_cnt", done_cnt[0], 3);
    chk("s2_runs",     runs0.size(), 3);
    chk("s2_gaps",     gaps0.size(), 2);
    foreach (runs0[k]) chk("s2_run_len", runs0[k], 164);
    foreach (gaps0[k]) chk("s2_gap_len", gaps0[k], 1);
    chk("s2_last_frame", cap[0][19:0], 20'h00FC0);

    // Scenario 3: input change and start pulse mid-frame
    clr_mon();
    A       = 9'h1C0;
    B       = 9'h007;
    start_v = 2'b01;
    @(negedge clk);
    start_v = 2'b00;
    repeat (40) @(negedge clk);
    A       = 9'h1FF;
    start_v = 2'b01;
    @(negedge clk);
    start_v = 2'b00;
    repeat (140) @(negedge clk);
    chk("s3_frame",    cap[0][19:0], 20'h00FC0);
    chk("s3_done_cnt", done_cnt[0],  1);
    chk("s3_busy_cyc", busy_cnt[0],  164);
    chk("s3_runs",     runs0.size(), 1);

    // Scenario 5: CLK_DIV=1 instance, all cells set, tie
    clr_mon();
    A       = 9'h1FF;
    B       = 9'h1FF;
    win     = 1'b0;
    tie     = 1'b1;
    start_v = 2'b10;
    @(negedge clk);
    start_v = 2'b00;
    repeat (50) @(negedge clk);
    chk("s5_frame",     cap[1][19:0], 20'h7FFFF);
    chk("s5_sclk_rise", rise[1],      20);
    chk("s5_busy_cyc",  busy_cnt[1],  41);
    chk("s5_done_cnt",  done_cnt[1],  1);
    chk("s5_latch_cyc", latch_cnt[1], 1);
    chk("s5_other_idle",busy_cnt[0],  0);

    // Scenario 4: reset during the sclk-high phase of bit 10
    clr_mon();
    A       = 9'h155;
    B       = 9'h0AA;
    win     = 1'b0;
    tie     = 1'b1;
    start_v = 2'b01;
    @(negedge clk);
    start_v = 2'b00;
    repeat (77) @(negedge clk);
    chk("s4_pre_sclk",  sclk_v[0],  1'b1);
    chk("s4_pre_sdata", sdata_v[0], 1'b1);
    rst = 1'b0;
    #1;
    chk("s4_rst_busy",  busy_v[0],  1'b0);
    chk("s4_rst_sclk",  sclk_v[0],  1'b0);
    chk("s4_rst_sdata", sdata_v[0], 1'b0);
    chk("s4_rst_latch", latch_v[0], 1'b0);
    chk("s4_rst_done",  done_v[0],  1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("s4_no_done", done_cnt[0], 0);
    clr_mon();
    start_v = 2'b01;
    @(negedge clk);
    start_v = 2'b00;
    repeat (170) @(negedge clk);
    chk("s4_frame",     cap[0][19:0], 20'h55555);
    chk("s4_sclk_rise", rise[0],      20);
    chk("s4_done_cnt",  done_cnt[0],  1);
    chk("s4_busy_cyc",  busy_cnt[0],  164);

`ifdef BOARD_LED_TX_WIN_BLINK_EN
    // Scenario 6: win blink across three back-to-back frames
    clr_mon();
    A       = 9'h000;
    B       = 9'h000;
    win     = 1'b1;
    tie     = 1'b0;
    start_v = 2'b01;
    repeat (340) @(negedge clk);
    start_v = 2'b00;
    repeat (200) @(negedge clk);
    chk("s6_done_cnt", done_cnt[0], 3);
    chk("s6_f1_win",   cap[0][59],  1'b1);
    chk("s6_f2_win",   cap[0][39],  1'b0);
    chk("s6_f3_win",   cap[0][19],  1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
